serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial multi-bit subtractor: computes A - B - Bin, LSB first, one bit per clock.
//  Built on the team's 1-bit full_sub cell (Diff = X^Y^Z, Borr = ~X&(Y^Z) | Y&Z).
//  The borrow is registered between bit slices.
//  Sits downstream of operand sources and upstream of result consumers.
//  Uses a start/busy/done handshake in place of a wide combinational ripple chain.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 1..32
// PORTS
//  clk    in   1      single clock, rising-edge
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      request; sampled only in IDLE
//  a      in   WIDTH  minuend, captured when start is accepted
//  b      in   WIDTH  subtrahend, captured when start is accepted
//  bin    in   1      borrow-in, captured when start is accepted
//  busy   out  1      high in SHIFT and DONE states
//  done   out  1      one-cycle pulse; result valid
//  diff   out  WIDTH  A - B - Bin modulo 2^WIDTH
//  bout   out  1      final borrow out (1 => unsigned A < B + Bin)
//  ovf    out  1      two's-complement overflow of the subtraction
// BEHAVIOUR
//  Reset (async, any time, incl. mid-operation):
//   - state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0.
//   - Shift registers, bit counter and borrow register cleared.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   - IDLE: start=1 at an edge loads a_sr=a, b_sr=b, brw=bin, cnt=0, saves a[W-1], b[W-1]; -> SHIFT.
//   - SHIFT: full_sub(X=a_sr[0], Y=b_sr[0], Z=brw).
//     - Diff shifts into MSB of the result register, which shifts right.
//     - brw <= Borr; a_sr, b_sr shift right; cnt++.
//     - After the cycle with cnt==WIDTH-1 -> DONE.
//   - DONE: done=1 for exactly this cycle.
//     - diff = result register; bout = brw.
//     - ovf = (a_msb != b_msb) && (diff[W-1] != a_msb).
//     - Next edge -> IDLE.
//  Latency: start sampled at edge 0 -> done high during the cycle after edge WIDTH
//   (WIDTH SHIFT cycles + 1 DONE cycle). Throughput: one op per WIDTH+1 cycles.
//  start while busy=1 (SHIFT or DONE) is ignored: no queuing, no corruption.
//   - start must be re-presented in IDLE.
//  diff/bout/ovf update only on entry to DONE; held stable until the next DONE.
//  a/b/bin may change freely after the accept edge.
//  cnt is $clog2(WIDTH)+1 bits wide; WIDTH=1 is legal (one SHIFT cycle).
//  No X propagation: all registers have reset values.
// STRUCTURE
//  Package sub_pkg:
//   - state typedef {IDLE, SHIFT, DONE}.
//   - MAX_WIDTH=32 constant.
//  Sub-module: one instance of full_sub (1-bit combinational slice).
//  Top holds the FSM, counter, shift registers and borrow register.
// TESTING (WIDTH=8 unless noted; check each result on the done cycle)
//  1. a=0x5A, b=0x3C, bin=0 -> diff=0x1E, bout=0, ovf=0.
//     done occurs exactly 9 cycles after the accept edge.
//  2. a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0.
//     a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
//  3. a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1.
//     a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
//  4. Start 0x5A-0x3C, then pulse start with a=0xFF, b=0x00 at cycles 3 and 9 (DONE).
//     Required: diff=0x1E; the second request is not executed.
//  5. Assert rst during SHIFT cycle 4 -> outputs 0 immediately, asynchronously.
//     After release, a new start with 0x00-0x01 gives 0xFF, bout=1.
//  6. WIDTH=1 build, all 8 (a,b,bin) combinations:
//     diff/bout match the full_sub truth table; done 2 cycles after accept.
//     Random 1000-op regression at WIDTH=8 vs (a-b-bin) reference model.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
//   state_t   : controller states (IDLE, SHIFT, DONE)
//   MAX_WIDTH : largest supported operand width
package sub_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// 1-bit combinational full subtractor slice: computes x - y - z.
//   x    in  minuend bit
//   y    in  subtrahend bit
//   z    in  borrow-in bit
//   diff out difference bit
//   borr out borrow-out bit
module full_sub (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic diff,
    output logic borr
);

    assign diff = x ^ y ^ z;
    assign borr = (~x & (y ^ z)) | (y & z);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
// The borrow is registered between slices.
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   start in   request, sampled only in IDLE
//   a, b  in   operands, captured on the accept edge
//   bin   in   borrow-in, captured on the accept edge
//   busy  out  high in SHIFT and DONE
//   done  out  one-cycle result-valid pulse
//   diff  out  a - b - bin modulo 2^WIDTH
//   bout  out  final borrow out
//   ovf   out  two's-complement overflow
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one bit slice per cycle, WIDTH cycles
// DONE  | results valid, done pulse
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             slice_diff;
    logic             slice_borr;
    logic [WIDTH-1:0] res_shifted;

    full_sub u_full_sub (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .z    (brw_q),
        .diff (slice_diff),
        .borr (slice_borr)
    );

    // New bit enters at the MSB; written as shift/or so WIDTH=1 needs no slice.
    assign res_shifted = (res_q >> 1) | (WIDTH'(slice_diff) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        brw_d   = brw_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d  = res_shifted;
                brw_d  = slice_borr;
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // Outputs are loaded only here, so they hold until the next DONE.
                    diff_d  = res_shifted;
                    bout_d  = slice_borr;
                    ovf_d   = (a_msb_q != b_msb_q) && (res_shifted[WIDTH-1] != a_msb_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8, ovf8;
    logic [7:0] diff8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       bin1 = 1'b0;
    logic       busy1, done1, bout1, ovf1;
    logic [0:0] diff1;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op on the 8-bit instance; lat = edges from accept to first done.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                        output logic [7:0] d, output logic bo, output logic ov, output int lat);
        @(negedge clk);
        start8 = 1'b1; a8 = av; b8 = bv; bin8 = bi;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        while (!done8 && lat < 30) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        d = diff8; bo = bout8; ov = ovf8;
    endtask

    task automatic run1(input logic av, input logic bv, input logic bi,
                        output logic d, output logic bo, output int lat);
        @(negedge clk);
        start1 = 1'b1; a1 = av; b1 = bv; bin1 = bi;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        start1 = 1'b0;
        while (!done1 && lat < 30) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        d = diff1[0]; bo = bout1;
    endtask

    initial begin
        vec_t       vecs[7];
        logic [7:0] d;
        logic       bo, ov, d1;
        int         lat;
        logic [8:0] ref9;
        logic       rov;
        logic [7:0] ra, rb;
        logic       rbi;
        logic       e_d, e_b;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        check("reset_busy", busy8, 0);
        check("reset_done", done8, 0);
        check("reset_diff", diff8, 0);
        check("reset_bout", bout8, 0);
        check("reset_ovf", ovf8, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, ov, lat);
            check($sformatf("vec%0d_latency", i), lat, 8);
            check($sformatf("vec%0d_diff", i), d, vecs[i].diff);
            check($sformatf("vec%0d_bout", i), bo, vecs[i].bout);
            check($sformatf("vec%0d_ovf", i), ov, vecs[i].ovf);
        end

        // start pulses while busy (mid-SHIFT and during DONE) must be ignored
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start8 = (k == 3 || k == 9);
            a8 = 8'hFF; b8 = 8'h00;
            if (k == 9) begin
                check("busy_start_done", done8, 1);
                check("busy_start_diff", diff8, 8'h1E);
            end
            @(posedge clk);
        end
        @(negedge clk);
        check("busy_start_idle", busy8, 0);
        check("busy_start_held", diff8, 8'h1E);

        // asynchronous reset in the middle of SHIFT
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", busy8, 0);
        check("async_rst_diff", diff8, 0);
        check("async_rst_done", done8, 0);
        @(negedge clk);
        rst = 1'b0;
        run8(8'h00, 8'h01, 1'b0, d, bo, ov, lat);
        check("post_rst_diff", d, 8'hFF);
        check("post_rst_bout", bo, 1);
        check("post_rst_latency", lat, 8);

        // WIDTH=1 instance against the full-subtractor truth table
        for (int c = 0; c < 8; c++) begin
            logic [2:0] cv;
            cv  = 3'(c);
            e_d = cv[2] ^ cv[1] ^ cv[0];
            e_b = (!cv[2] && (cv[1] || cv[0]) && !(cv[1] && cv[0])) || (cv[1] && cv[0]);
            run1(cv[2], cv[1], cv[0], d1, bo, lat);
            check($sformatf("w1_%0d_latency", c), lat, 1);
            check($sformatf("w1_%0d_diff", c), d1, e_d);
            check($sformatf("w1_%0d_bout", c), bo, e_b);
        end

        // random regression against an arithmetic reference
        for (int n = 0; n < 1000; n++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbi  = 1'($urandom);
            ref9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
            rov  = (ra[7] != rb[7]) && (ref9[7] != ra[7]);
            run8(ra, rb, rbi, d, bo, ov, lat);
            check($sformatf("rnd%0d_diff a=%0h b=%0h bin=%0d", n, ra, rb, rbi), d, ref9[7:0]);
            check($sformatf("rnd%0d_bout", n), bo, ref9[8]);
            check($sformatf("rnd%0d_ovf", n), ov, rov);
            if (lat != 8) check($sformatf("rnd%0d_latency", n), lat, 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
